// File: rtl/data_mem_arbiter.sv
// Two-requester (core, debug/loader) arbiter in front of a single-port data RAM.
// Define ARB_CORE_PRIORITY_EN for fixed core priority; default build is round-robin.
module data_mem_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  core_req_i,
    input  logic                  core_we_i,
    input  logic [DATA_WIDTH-1:0] core_addr_i,
    input  logic [DATA_WIDTH-1:0] core_wdata_i,
    output logic                  core_gnt_o,
    output logic                  core_rvalid_o,
    output logic [DATA_WIDTH-1:0] core_rdata_o,
    input  logic                  dbg_req_i,
    input  logic                  dbg_we_i,
    input  logic [DATA_WIDTH-1:0] dbg_addr_i,
    input  logic [DATA_WIDTH-1:0] dbg_wdata_i,
    output logic                  dbg_gnt_o,
    output logic                  dbg_rvalid_o,
    output logic [DATA_WIDTH-1:0] dbg_rdata_o,
    output logic [DATA_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    output logic                  ram_rd_en_o,
    output logic                  ram_wr_en_o,
    input  logic [DATA_WIDTH-1:0] ram_q_i,
    output logic                  busy_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic                  we_q;
    logic                  win_dbg_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  grant_any;
    logic                  pick_dbg;
    logic                  win_we;

    // Gating with reset_i keeps grants low while reset is held, even with requests up.
    assign grant_any = reset_i && (state_q == ST_IDLE) && (core_req_i || dbg_req_i);

`ifdef ARB_CORE_PRIORITY_EN
    assign pick_dbg = dbg_req_i && !core_req_i;
`else
    logic last_dbg_q;

    // last_dbg_q resets high so the core takes the first tie.
    assign pick_dbg = dbg_req_i && (!core_req_i || !last_dbg_q);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            last_dbg_q <= 1'b1;
        end else if (grant_any) begin
            last_dbg_q <= pick_dbg;
        end
    end
`endif

    assign core_gnt_o = grant_any && !pick_dbg;
    assign dbg_gnt_o  = grant_any && pick_dbg;
    assign win_we     = pick_dbg ? dbg_we_i : core_we_i;

    always_comb begin
        // NOTE: default assignment first so no branch leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (grant_any) state_d = ST_ACCESS;
            ST_ACCESS: state_d = we_q ? ST_IDLE : ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            win_dbg_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (grant_any) begin
                we_q      <= win_we;
                win_dbg_q <= pick_dbg;
                addr_q    <= pick_dbg ? dbg_addr_i : core_addr_i;
                wdata_q   <= pick_dbg ? dbg_wdata_i : core_wdata_i;
            end
        end
    end

    // Address/data hold the last latched operands; only the enables are qualified by ACCESS.
    assign ram_addr_o  = addr_q;
    assign ram_data_o  = wdata_q;
    assign ram_rd_en_o = (state_q == ST_ACCESS) && !we_q;
    assign ram_wr_en_o = (state_q == ST_ACCESS) && we_q;

    assign core_rvalid_o = (state_q == ST_RESP) && !win_dbg_q;
    assign dbg_rvalid_o  = (state_q == ST_RESP) && win_dbg_q;
    assign core_rdata_o  = core_rvalid_o ? ram_q_i : '0;
    assign dbg_rdata_o   = dbg_rvalid_o ? ram_q_i : '0;

    assign busy_o = (state_q != ST_IDLE);

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of all data and address buses.
REQ-002 Port clk_i  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 Port reset_i  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 Ports core_req_i / core_we_i SHALL be inputs, width 1: core access request and write flag (0 = read).
REQ-005 Ports core_addr_i / core_wdata_i SHALL be inputs, width DATA_WIDTH: core byte address and write data.
REQ-006 Ports core_gnt_o / core_rvalid_o SHALL be outputs, width 1: request accepted, and read data valid.
REQ-007 Port core_rdata_o SHALL be an output, width DATA_WIDTH: core read data.
REQ-008 Ports dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, dbg_gnt_o, dbg_rvalid_o and dbg_rdata_o SHALL mirror REQ-004..007 for the debug/loader requester.
REQ-009 Ports ram_addr_o / ram_data_o SHALL be outputs, width DATA_WIDTH: data memory address and write data.
REQ-010 Ports ram_rd_en_o / ram_wr_en_o SHALL be outputs, width 1: data memory read and write enables.
REQ-011 Port ram_q_i SHALL be an input, width DATA_WIDTH: data memory read data, valid the cycle after ram_rd_en_o.
REQ-012 Port busy_o SHALL be an output, width 1: high whenever state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, ACCESS and RESP.
REQ-014 In IDLE with at least one req_i high, the arbiter SHALL pick one winner and assert its gnt_o for that cycle only.
REQ-015 On the grant edge, the arbiter SHALL latch the winner's addr, wdata, we and identity, then enter ACCESS.
REQ-016 The requester SHALL treat gnt_o high at a rising edge as handshake complete; its req_i and operands are don't-care afterwards.
REQ-017 In ACCESS, the block SHALL drive ram_addr_o and ram_data_o from the latched values for exactly one cycle.
REQ-018 In ACCESS, the block SHALL assert ram_wr_en_o if the latched we=1, else ram_rd_en_o.
REQ-019 After ACCESS, a write SHALL go to IDLE and a read SHALL go to RESP.
REQ-020 In RESP, the block SHALL assert the winner's rvalid_o for one cycle, drive its rdata_o = ram_q_i, then go to IDLE.
REQ-021 Latency SHALL be: grant to RAM enable = 1 cycle; grant to rvalid = 2 cycles.
REQ-022 Throughput SHALL be: one write per 2 cycles; one read per 3 cycles.
REQ-023 The non-winning rdata_o SHALL be 0; rdata_o SHALL be 0 whenever rvalid_o is 0.
REQ-024 In ACCESS and RESP, both gnt_o SHALL be 0; requests arriving then SHALL wait for IDLE and SHALL NOT be lost while held high.
REQ-025 A req_i dropped before its grant SHALL be ignored, with no RAM access.
REQ-026 Default arbitration SHALL be round-robin on simultaneous requests: the requester not granted most recently wins.
REQ-027 The last-winner register SHALL update only on a grant.
REQ-028 A single requester SHALL always win, regardless of the last winner.
REQ-029 Outside ACCESS, ram_rd_en_o and ram_wr_en_o SHALL be 0 and ram_addr_o/ram_data_o SHALL hold the last latched values.

Reset
REQ-030 reset_i low SHALL immediately force state IDLE, the last winner to dbg (so the core wins the first tie), and latched operands to 0.
REQ-031 During reset, every output SHALL be 0.
REQ-032 Reset asserted during ACCESS or RESP SHALL abort the transfer; RAM enables and rvalid_o SHALL drop immediately and no response SHALL follow.
REQ-033 After reset release, the first grant SHALL occur no earlier than the first rising edge with reset_i high.

Configuration
REQ-034 With macro ARB_CORE_PRIORITY_EN defined, arbitration SHALL be fixed priority: core always wins simultaneous requests and the last-winner register SHALL be absent.
REQ-035 Without ARB_CORE_PRIORITY_EN, round-robin per REQ-026 SHALL apply.

Verification
REQ-036 Core read only: core_req=1, we=0, addr=0x10, RAM returns 0xDEADBEEF -> core_gnt at cycle 0, ram_rd_en=1 with addr 0x10 at cycle 1, core_rvalid=1 with rdata 0xDEADBEEF at cycle 2.
REQ-037 Dbg write: dbg_req=1, we=1, addr=0x20, wdata=0x12345678 -> ram_wr_en=1 with those values for one cycle; no rvalid; IDLE 2 cycles after grant.
REQ-038 Both requests held continuously (round-robin build) -> grants alternate core, dbg, core, dbg starting with core after reset.
REQ-039 Same as REQ-038 with ARB_CORE_PRIORITY_EN defined -> core granted every time; dbg never granted while core_req is held.
REQ-040 Request during busy: core read in progress, dbg_req rises in ACCESS -> no dbg_gnt until IDLE, then dbg granted; core_rvalid unaffected.
REQ-041 Reset in RESP: reset_i low during RESP -> rvalid, ram enables and gnt go 0 at once; state IDLE after release.
